// File: rtl/common.sv
// Bus types shared between pipeline stages and the memory side.
package common;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

endpackage

// File: rtl/pipes.sv
// Pipeline-stage types and constants for the fetch/decode boundary.
package pipes;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        DISCARD = 2'd1,
        HOLD    = 2'd2
    } fetch_state_t;

    localparam logic [63:0] PC_RESET_DEFAULT = 64'h0000_0000_8000_0000;
    localparam logic [63:0] INSTR_BYTES      = 64'd4;

    typedef struct packed {
        logic        valid;
        logic [63:0] pc;
        logic [31:0] raw_instr;
    } fetch_data_t;

    function automatic logic [63:0] seq_pc(input logic [63:0] pc);
        return pc + INSTR_BYTES;
    endfunction

endpackage

// File: rtl/fetch_pcnext.sv
// Next fetch PC selection: an unstalled redirect beats a sequential advance.
module pcnext
    import pipes::*;
(
    input  logic [63:0] pc,
    input  logic        PCSel,
    input  logic [63:0] pc_address,
    input  logic        stallF,
    input  logic        deliver,
    output logic [63:0] pc_next,
    output logic        redirect
);

    always_comb begin
        redirect = PCSel && !stallF;
        pc_next  = pc;
        if (redirect) begin
            pc_next = pc_address;
        end else if (deliver) begin
            pc_next = seq_pc(pc);
        end
    end

endmodule

// File: rtl/fetch.sv
// Instruction-fetch stage and F/D pipeline register.
//
// state   | meaning
// FETCH   | request at req_addr on the bus, waiting for data_ok
// DISCARD | redirected with a request in flight; drop its data when it lands
// HOLD    | data arrived while decode stalled; parked in buf_* until released
module fetch
    import common::*;
    import pipes::*;
#(
    parameter logic [63:0] PC_RESET = PC_RESET_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    output ibus_req_t   ireq,
    input  ibus_resp_t  iresp,
    input  logic        stallF,
    input  logic        PCSel,
    input  logic [63:0] pc_address,
    output fetch_data_t dataF,
    output logic [63:0] last_pc
);

    fetch_state_t state_q, state_d;
    logic [63:0]  pc_q, pc_d;
    logic [63:0]  req_addr_q, req_addr_d;
    logic [31:0]  buf_instr_q, buf_instr_d;
    logic [63:0]  buf_pc_q, buf_pc_d;
    fetch_data_t  data_f_q, data_f_d;

    logic         deliver_cand;
    logic         redirect;
    logic [63:0]  pc_next;
    logic [63:0]  deliver_pc;
    logic [31:0]  deliver_instr;
    logic         unused_addr_ok;

    // A response is outstanding until data_ok; the accept handshake carries no information here.
    assign unused_addr_ok = iresp.addr_ok;

    // Candidate only; pcnext lets an effective redirect override it.
    assign deliver_cand = !stallF &&
                          (((state_q == FETCH) && iresp.data_ok) || (state_q == HOLD));

    pcnext u_pcnext (
        .pc         (pc_q),
        .PCSel      (PCSel),
        .pc_address (pc_address),
        .stallF     (stallF),
        .deliver    (deliver_cand),
        .pc_next    (pc_next),
        .redirect   (redirect)
    );

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_next;
        req_addr_d    = req_addr_q;
        buf_instr_d   = buf_instr_q;
        buf_pc_d      = buf_pc_q;
        data_f_d      = data_f_q;
        deliver_pc    = buf_pc_q;
        deliver_instr = buf_instr_q;

        case (state_q)
            FETCH: begin
                if (iresp.data_ok) begin
                    if (redirect) begin
                        req_addr_d = pc_next;
                    end else if (!stallF) begin
                        deliver_pc    = req_addr_q;
                        deliver_instr = iresp.data;
                        req_addr_d    = pc_next;
                    end else begin
                        buf_instr_d = iresp.data;
                        buf_pc_d    = req_addr_q;
                        state_d     = HOLD;
                    end
                end else if (redirect) begin
                    state_d = DISCARD;
                end
            end
            DISCARD: begin
                if (iresp.data_ok) begin
                    req_addr_d = pc_next;
                    state_d    = FETCH;
                end
            end
            HOLD: begin
                if (!stallF) begin
                    req_addr_d = pc_next;
                    state_d    = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase

        if (!stallF) begin
            data_f_d = '0;
            if (deliver_cand && !redirect) begin
                data_f_d.valid     = 1'b1;
                data_f_d.pc        = deliver_pc;
                data_f_d.raw_instr = deliver_instr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= FETCH;
            pc_q        <= PC_RESET;
            req_addr_q  <= PC_RESET;
            buf_instr_q <= '0;
            buf_pc_q    <= '0;
            data_f_q    <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_addr_q  <= req_addr_d;
            buf_instr_q <= buf_instr_d;
            buf_pc_q    <= buf_pc_d;
            data_f_q    <= data_f_d;
        end
    end

    always_comb begin
        ireq.valid = !reset && ((state_q == FETCH) || (state_q == DISCARD));
        ireq.addr  = req_addr_q;
    end

    assign dataF   = data_f_q;
    assign last_pc = pc_q;

endmodule

// File: tb/tb_fetch.sv
// Directed bench for fetch with a scoreboard of expected F/D deliveries.
module tb_fetch;
    import common::*;
    import pipes::*;

    logic        clk;
    logic        reset;
    ibus_req_t   ireq;
    ibus_resp_t  iresp;
    logic        stallF;
    logic        PCSel;
    logic [63:0] pc_address;
    fetch_data_t dataF;
    logic [63:0] last_pc;

    int total;
    int bad;
    fetch_data_t sb[$];
    fetch_data_t exp_df;

    fetch dut (
        .clk        (clk),
        .reset      (reset),
        .ireq       (ireq),
        .iresp      (iresp),
        .stallF     (stallF),
        .PCSel      (PCSel),
        .pc_address (pc_address),
        .dataF      (dataF),
        .last_pc    (last_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [63:0] a);
        return {a[31:2], 2'b11} ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [63:0] a);
        fetch_data_t e;
        e.valid     = 1'b1;
        e.pc        = a;
        e.raw_instr = instr_of(a);
        sb.push_back(e);
    endtask

    task automatic chk_req(input string tag, input logic v, input logic [63:0] a);
        chk({tag, "_valid"}, 128'(ireq.valid), 128'(v));
        if (v) chk({tag, "_addr"}, 128'(ireq.addr), 128'(a));
    endtask

    // One clock: drive bus/decode inputs, advance, then check dataF against the scoreboard.
    task automatic cyc(input bit dok, input bit stl, input bit sel, input logic [63:0] tgt,
                       input bit exp_dv);
        fetch_data_t e;
        iresp.addr_ok = dok;
        iresp.data_ok = dok;
        iresp.data    = instr_of(ireq.addr);
        stallF        = stl;
        PCSel         = sel;
        pc_address    = tgt;
        @(posedge clk);
        #1;
        iresp.addr_ok = 1'b0;
        iresp.data_ok = 1'b0;
        iresp.data    = '0;
        stallF        = 1'b0;
        PCSel         = 1'b0;
        pc_address    = '0;
        if (reset) begin
            sb.delete();
            exp_df = '0;
            chk("reset_dataF", 128'(dataF), 128'(0));
        end else if (stl) begin
            if (exp_df.valid) chk("hold_dataF", 128'(dataF), 128'(exp_df));
            else              chk("hold_bubble", 128'(dataF.valid), 128'(0));
        end else if (exp_dv) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $error("FAIL sb_underflow: observed=empty expected=entry");
            end else begin
                e = sb.pop_front();
                chk("deliver_dataF", 128'(dataF), 128'(e));
                exp_df = e;
            end
        end else begin
            chk("bubble_valid", 128'(dataF.valid), 128'(0));
            exp_df = '0;
        end
    endtask

    initial begin
        logic [63:0] a;
        total = 0;
        bad   = 0;
        exp_df = '0;
        reset = 1'b1;
        iresp = '0;
        stallF = 1'b0;
        PCSel = 1'b0;
        pc_address = '0;

        // Reset, then zero-wait bus.
        #1;
        chk("rst_ireq_valid", 128'(ireq.valid), 128'(0));
        cyc(0, 0, 0, '0, 0);
        cyc(0, 0, 0, '0, 0);
        chk("rst_last_pc", 128'(last_pc), 128'(64'h8000_0000));
        chk("rst_ireq_valid2", 128'(ireq.valid), 128'(0));
        reset = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            a = 64'h8000_0000 + 64'(4 * i);
            chk_req("zw_req", 1'b1, a);
            push_exp(a);
            cyc(1, 0, 0, '0, 1);
            chk("zw_last_pc", 128'(last_pc), 128'(a + 64'd4));
        end

        // Two wait states, then a stall of three cycles on the next response.
        reset = 1'b1;
        cyc(0, 0, 0, '0, 0);
        reset = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk_req("ws_req", 1'b1, 64'h8000_0000);
            cyc(0, 0, 0, '0, 0);
        end
        chk_req("ws_req", 1'b1, 64'h8000_0000);
        push_exp(64'h8000_0000);
        cyc(1, 0, 0, '0, 1);
        chk_req("st_req", 1'b1, 64'h8000_0004);
        push_exp(64'h8000_0004);
        cyc(1, 1, 0, '0, 0);
        chk("st_hold_ireq", 128'(ireq.valid), 128'(0));
        cyc(0, 1, 0, '0, 0);
        chk("st_hold_ireq2", 128'(ireq.valid), 128'(0));
        cyc(0, 1, 0, '0, 0);
        chk("st_hold_ireq3", 128'(ireq.valid), 128'(0));
        cyc(0, 0, 0, '0, 1);

        // Redirect while 8000_0008 is outstanding.
        chk_req("rd_req", 1'b1, 64'h8000_0008);
        cyc(0, 0, 1, 64'h8000_0100, 0);
        chk("rd_last_pc", 128'(last_pc), 128'(64'h8000_0100));
        chk("rd_state", 128'(dut.state_q), 128'(DISCARD));
        chk_req("rd_disc_req", 1'b1, 64'h8000_0008);
        cyc(0, 0, 0, '0, 0);
        chk_req("rd_disc_req2", 1'b1, 64'h8000_0008);
        cyc(1, 0, 0, '0, 0);
        chk_req("rd_tgt_req", 1'b1, 64'h8000_0100);
        push_exp(64'h8000_0100);
        cyc(1, 0, 0, '0, 1);

        // PCSel under stall is ignored, then taken once unstalled.
        chk_req("ss_req", 1'b1, 64'h8000_0104);
        cyc(0, 1, 1, 64'h8000_0200, 0);
        chk("ss_last_pc", 128'(last_pc), 128'(64'h8000_0104));
        cyc(0, 0, 1, 64'h8000_0200, 0);
        chk("ss_last_pc2", 128'(last_pc), 128'(64'h8000_0200));
        chk("ss_state", 128'(dut.state_q), 128'(DISCARD));

        // Reset while in DISCARD.
        reset = 1'b1;
        #1;
        chk("rd_rst_ireq", 128'(ireq.valid), 128'(0));
        cyc(0, 0, 0, '0, 0);
        chk("rd_rst_state", 128'(dut.state_q), 128'(FETCH));
        chk("rd_rst_pc", 128'(last_pc), 128'(64'h8000_0000));
        reset = 1'b0;
        #1;

        // data_ok and redirect together: data dropped, target two cycles later.
        chk_req("dr_req", 1'b1, 64'h8000_0000);
        cyc(1, 0, 1, 64'h8000_0300, 0);
        chk_req("dr_tgt_req", 1'b1, 64'h8000_0300);
        chk("dr_last_pc", 128'(last_pc), 128'(64'h8000_0300));
        push_exp(64'h8000_0300);
        cyc(1, 0, 0, '0, 1);

        // 64-bit wrap of the sequential PC.
        chk_req("wr_req", 1'b1, 64'h8000_0304);
        cyc(1, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0);
        chk_req("wr_top_req", 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
        push_exp(64'hFFFF_FFFF_FFFF_FFFC);
        cyc(1, 0, 0, '0, 1);
        chk_req("wr_zero_req", 1'b1, 64'h0);
        chk("wr_last_pc", 128'(last_pc), 128'(64'h0));

        chk("sb_drained", 128'(sb.size()), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
